// File: rtl/sched_axis_mux.sv
// sched_axis_mux
//   Packet-granular AXI-Stream output mux downstream of the PIEO scheduler tree.
//   It samples the scheduler's FIFO index and enable only while idle, locks onto
//   that FIFO, and forwards whole packets with zero added latency. A registered
//   one-hot end-of-packet pulse (pe_tlast) goes back to the scheduler.
//
// Optional feature: define SCHED_AXIS_MUX_STATS_EN to add the packet and byte
//   counters stat_pkt_cnt / stat_byte_cnt.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   sel_in, en_in   scheduler-selected FIFO index and selection valid
//   s_axis_*        NUM_FIFO flattened AXIS slave inputs; FIFO i at slice i
//   m_axis_*        single AXIS master output
//   pe_tlast        one-cycle pulse: the last beat of FIFO i was accepted
//   busy            high while forwarding a packet or in the post-packet gap
//   stat_*          (stats build only) accepted packet / byte counters, wrap at 2^32
module sched_axis_mux #(
    parameter int unsigned NUM_FIFO   = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_FIFO)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SEL_WIDTH-1:0]           sel_in,
    input  logic                           en_in,
    input  logic [NUM_FIFO*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_FIFO*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_FIFO-1:0]            s_axis_tvalid,
    input  logic [NUM_FIFO-1:0]            s_axis_tlast,
    output logic [NUM_FIFO-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [NUM_FIFO-1:0]            pe_tlast,
`ifdef SCHED_AXIS_MUX_STATS_EN
    output logic [31:0]                    stat_pkt_cnt,
    output logic [31:0]                    stat_byte_cnt,
`endif
    output logic                           busy
);

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StGap
    } state_e;

    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [NUM_FIFO-1:0]   pe_q, pe_d;
    logic                  sel_ok;
    logic                  start;
    logic                  last_hs;

    // Widen by one bit so the range check also works when NUM_FIFO is a power of two.
    assign sel_ok  = ({1'b0, sel_in} < (SEL_WIDTH + 1)'(NUM_FIFO));
    assign start   = en_in && sel_ok && s_axis_tvalid[sel_in];
    assign last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Combinational datapath: only the locked FIFO is visible, and only in StFwd.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == StFwd) begin
            for (int unsigned i = 0; i < NUM_FIFO; i++) begin
                if (sel_q == SEL_WIDTH'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pe_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFwd;
                    sel_d   = sel_in;
                end
            end
            StFwd: begin
                // The pulse is registered, so it appears during StGap.
                if (last_hs) begin
                    state_d     = StGap;
                    pe_d[sel_q] = 1'b1;
                end
            end
            StGap: begin
                // One dead cycle lets the scheduler advance before the next sample.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            pe_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pe_q    <= pe_d;
        end
    end

    assign pe_tlast = pe_q;
    assign busy     = (state_q != StIdle);

`ifdef SCHED_AXIS_MUX_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] byte_cnt_q;
    logic [31:0] keep_pop;

    always_comb begin
        keep_pop = '0;
        for (int unsigned k = 0; k < KEEP_WIDTH; k++) begin
            keep_pop = keep_pop + 32'(m_axis_tkeep[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            byte_cnt_q <= byte_cnt_q + keep_pop;
            if (m_axis_tlast) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_sched_axis_mux.sv
module tb_sched_axis_mux;

    localparam int unsigned NF = 12;
    localparam int unsigned DW = 64;
    localparam int unsigned KW = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       sel_in;
    logic             en_in;
    logic [NF*DW-1:0] s_tdata;
    logic [NF*KW-1:0] s_tkeep;
    logic [NF-1:0]    s_tvalid;
    logic [NF-1:0]    s_tlast;
    logic [NF-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic [NF-1:0]    pe_tlast;
    logic             busy;
`ifdef SCHED_AXIS_MUX_STATS_EN
    logic [31:0]      stat_pkt_cnt;
    logic [31:0]      stat_byte_cnt;
`endif

    sched_axis_mux dut (
        .clk           (clk),
        .rst           (rst),
        .sel_in        (sel_in),
        .en_in         (en_in),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .pe_tlast      (pe_tlast),
`ifdef SCHED_AXIS_MUX_STATS_EN
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_byte_cnt (stat_byte_cnt),
`endif
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Upstream FIFO source state: packet length, current beat, last-beat tkeep.
    int       pkt_len  [NF];
    int       beat_idx [NF];
    logic [7:0] keep_last [NF];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beat data = A000_0000_0000_<fifo><beat>.
    task automatic drive_src();
        for (int i = 0; i < NF; i++) begin
            logic [63:0] d;
            d = 64'hA000_0000_0000_0000 | (64'(i) << 8) | 64'(beat_idx[i]);
            s_tdata[i*DW +: DW] = d;
            s_tvalid[i] = (beat_idx[i] < pkt_len[i]);
            s_tlast[i]  = (beat_idx[i] < pkt_len[i]) && (beat_idx[i] == pkt_len[i] - 1);
            s_tkeep[i*KW +: KW] = s_tlast[i] ? keep_last[i] : 8'hFF;
        end
    endtask

    task automatic load(input int f, input int len);
        pkt_len[f]  = len;
        beat_idx[f] = 0;
        drive_src();
    endtask

    // Advance one clock; the source pops a beat wherever a handshake occurred.
    task automatic tick();
        logic [NF-1:0] acc;
        acc = s_tready & s_tvalid;
        @(posedge clk);
        #1;
        for (int i = 0; i < NF; i++) begin
            if (acc[i]) beat_idx[i]++;
        end
        drive_src();
    endtask

    initial begin
        for (int i = 0; i < NF; i++) begin
            pkt_len[i]   = 0;
            beat_idx[i]  = 0;
            keep_last[i] = 8'hFF;
        end
        rst      = 1'b1;
        sel_in   = 4'd0;
        en_in    = 1'b0;
        m_tready = 1'b0;
        drive_src();
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pe", 64'(pe_tlast), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // T1 basic: FIFO5, 3 beats, m_tready=1.
        load(5, 3);
        en_in = 1'b1; sel_in = 4'd5; m_tready = 1'b1;
        #1;
        chk("t1_c0_busy", 64'(busy), 64'd0);
        chk("t1_c0_mvalid", 64'(m_tvalid), 64'd0);
        tick(); en_in = 1'b0; #1;
        chk("t1_c1_data", m_tdata, 64'hA000_0000_0000_0500);
        chk("t1_c1_tready", 64'(s_tready), 64'h020);
        chk("t1_c1_busy", 64'(busy), 64'd1);
        chk("t1_c1_last", 64'(m_tlast), 64'd0);
        tick(); #1;
        chk("t1_c2_data", m_tdata, 64'hA000_0000_0000_0501);
        tick(); #1;
        chk("t1_c3_data", m_tdata, 64'hA000_0000_0000_0502);
        chk("t1_c3_last", 64'(m_tlast), 64'd1);
        chk("t1_c3_pe", 64'(pe_tlast), 64'd0);
        tick(); #1;
        chk("t1_c4_pe", 64'(pe_tlast), 64'h020);
        chk("t1_c4_busy", 64'(busy), 64'd1);
        chk("t1_c4_mvalid", 64'(m_tvalid), 64'd0);
        chk("t1_c4_tready", 64'(s_tready), 64'd0);
        tick(); #1;
        chk("t1_c5_pe", 64'(pe_tlast), 64'd0);
        chk("t1_c5_busy", 64'(busy), 64'd0);

        // T2 backpressure: m_tready 1,0,1,0,1.
        load(5, 3);
        en_in = 1'b1; sel_in = 4'd5;
        tick(); en_in = 1'b0; m_tready = 1'b1; #1;
        chk("t2_b0_data", m_tdata, 64'hA000_0000_0000_0500);
        tick(); m_tready = 1'b0; #1;
        chk("t2_b1_data_stall", m_tdata, 64'hA000_0000_0000_0501);
        chk("t2_b1_tready_stall", 64'(s_tready), 64'd0);
        tick(); m_tready = 1'b1; #1;
        chk("t2_b1_data", m_tdata, 64'hA000_0000_0000_0501);
        tick(); m_tready = 1'b0; #1;
        chk("t2_b2_data_stall", m_tdata, 64'hA000_0000_0000_0502);
        chk("t2_b2_pe_stall", 64'(pe_tlast), 64'd0);
        chk("t2_b2_busy_stall", 64'(busy), 64'd1);
        tick(); m_tready = 1'b1; #1;
        chk("t2_b2_data", m_tdata, 64'hA000_0000_0000_0502);
        chk("t2_b2_pe", 64'(pe_tlast), 64'd0);
        tick(); #1;
        chk("t2_gap_pe", 64'(pe_tlast), 64'h020);
        tick(); #1;
        chk("t2_idle_pe", 64'(pe_tlast), 64'd0);
        chk("t2_idle_busy", 64'(busy), 64'd0);

        // T3 mid-packet reselect: FIFO2 4 beats, sel_in moves to 7.
        keep_last[2] = 8'h3F;
        load(2, 4);
        load(7, 2);
        en_in = 1'b1; sel_in = 4'd2;
        tick(); sel_in = 4'd7; #1;
        chk("t3_b0_data", m_tdata, 64'hA000_0000_0000_0200);
        tick(); #1;
        chk("t3_b1_data", m_tdata, 64'hA000_0000_0000_0201);
        chk("t3_b1_tready", 64'(s_tready), 64'h004);
        tick(); #1;
        chk("t3_b2_data", m_tdata, 64'hA000_0000_0000_0202);
        tick(); #1;
        chk("t3_b3_data", m_tdata, 64'hA000_0000_0000_0203);
        chk("t3_b3_keep", 64'(m_tkeep), 64'h3F);
        chk("t3_b3_last", 64'(m_tlast), 64'd1);
        tick(); #1;
        chk("t3_gap_pe", 64'(pe_tlast), 64'h004);
        chk("t3_gap_tready", 64'(s_tready), 64'd0);
        en_in = 1'b0;
        tick(); #1;
        chk("t3_idle_pe", 64'(pe_tlast), 64'd0);
        chk("t3_fifo7_left", 64'(beat_idx[7]), 64'd0);
        load(7, 0);

        // T4 guards: out-of-range index, and a FIFO with nothing valid.
        en_in = 1'b1; sel_in = 4'd12;
        tick(); #1;
        chk("t4_oor_busy", 64'(busy), 64'd0);
        chk("t4_oor_mvalid", 64'(m_tvalid), 64'd0);
        chk("t4_oor_pe", 64'(pe_tlast), 64'd0);
        sel_in = 4'd3;
        tick(); #1;
        chk("t4_nv_busy", 64'(busy), 64'd0);
        chk("t4_nv_tready", 64'(s_tready), 64'd0);
        tick(); #1;
        chk("t4_nv_pe", 64'(pe_tlast), 64'd0);
        en_in = 1'b0;

        // T5 reset abort at beat 2 of a 5-beat packet.
        load(4, 5);
        en_in = 1'b1; sel_in = 4'd4;
        tick(); en_in = 1'b0; #1;
        chk("t5_b0_data", m_tdata, 64'hA000_0000_0000_0400);
        tick(); #1;
        chk("t5_b1_data", m_tdata, 64'hA000_0000_0000_0401);
        rst = 1'b1;
        #1;
        chk("t5_rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_tready", 64'(s_tready), 64'd0);
        chk("t5_rst_data", m_tdata, 64'd0);
        tick();
        rst = 1'b0;
        tick(); #1;
        chk("t5_post_busy", 64'(busy), 64'd0);
        chk("t5_post_pe", 64'(pe_tlast), 64'd0);
        tick(); #1;
        chk("t5_post_pe2", 64'(pe_tlast), 64'd0);
        load(4, 0);

`ifdef SCHED_AXIS_MUX_STATS_EN
        // T6 stats: two 3-beat packets from FIFO1, last tkeep=0F -> 2 pkts, 40 bytes.
        keep_last[1] = 8'h0F;
        chk("t6_init_pkt", stat_pkt_cnt, 64'd0);
        for (int p = 0; p < 2; p++) begin
            load(1, 3);
            en_in = 1'b1; sel_in = 4'd1;
            tick(); en_in = 1'b0;
            for (int c = 0; c < 5; c++) tick();
        end
        #1;
        chk("t6_pkt_cnt", stat_pkt_cnt, 64'd2);
        chk("t6_byte_cnt", stat_byte_cnt, 64'd40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
